// File: rtl/counter_arbiter_pkg.sv
// ============================================================================
// Module  : counter_arbiter_pkg
// Purpose : Shared definitions for the counter arbiter: requester opcode
//           encodings and the sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_arbiter_pkg;

  // Requester opcodes, two bits per requester on the op bus
  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  // Sequencer states: one operation every three cycles
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/counter_arbiter_counter.sv
// ============================================================================
// Module  : counter_arbiter_counter
// Purpose : The shared counter datapath. Control priority res > load > inc.
// Ports   : o    - counter value
//           in   - load data
//           res  - synchronous clear (active high)
//           load - load 'in'
//           inc  - increment by one (wraps modulo 2**WIDTH)
//           clk  - rising-edge clock
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_arbiter_counter #(
  parameter int WIDTH = 16
) (
  output logic [WIDTH-1:0] o,
  input  logic [WIDTH-1:0] in,
  input  logic             res,
  input  logic             load,
  input  logic             inc,
  input  logic             clk
);

  always_ff @(posedge clk) begin
    if (res)       o <= '0;
    else if (load) o <= in;
    else if (inc)  o <= o + 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/counter_arbiter.sv
// ============================================================================
// Module  : counter_arbiter
// Purpose : Round-robin arbiter/sequencer sharing one signed counter between
//           NREQ requesters. IDLE picks a winner and latches its operation,
//           ISSUE drives one counter control, ACK pulses gnt with the result.
// Ports   : clk   - rising-edge clock
//           res   - synchronous active-high reset (aborts in-flight op)
//           req   - per-requester request level
//           op    - per-requester opcode, [2i+1:2i]
//           din   - per-requester load value, [WIDTH*(i+1)-1:WIDTH*i]
//           gnt   - one-hot completion pulse
//           count - counter value
//           busy  - high in ISSUE and ACK
//           ovf   - saturation flag aligned with gnt
// Config  : COUNTER_ARB_SAT_EN - INC at the maximum positive value holds the
//           count and raises ovf; otherwise INC wraps and ovf is 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  ovf
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   win;
  logic [IDXW-1:0]   pick;
  logic [1:0]        lat_op;
  logic [WIDTH-1:0]  lat_din;
  logic              ctr_res, ctr_load, ctr_inc;
  logic              issue_inc;

  // First asserted request scanning upward from p, wrapping modulo NREQ
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] p);
    logic [IDXW-1:0] sel;
    logic            found;
    int              idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        sel   = IDXW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, ptr);

  // State register
  always_ff @(posedge clk) begin
    if (res) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Winner latch and round-robin pointer. The operation is captured in IDLE
  // so later changes on req/op/din cannot disturb it.
  always_ff @(posedge clk) begin
    if (res) begin
      ptr     <= '0;
      win     <= '0;
      lat_op  <= OP_READ;
      lat_din <= '0;
    end else begin
      if (state == S_IDLE && (|req)) begin
        win     <= pick;
        lat_op  <= op[2*int'(pick) +: 2];
        lat_din <= din[WIDTH*int'(pick) +: WIDTH];
      end
      if (state == S_ACK)
        ptr <= (win == IDXW'(NREQ-1)) ? '0 : win + 1'b1;
    end
  end

  // Counter controls: at most one asserted, only in ISSUE. A global reset
  // also clears the counter through its res input.
  assign issue_inc = (state == S_ISSUE) && (lat_op == OP_INC);
  assign ctr_res   = res | ((state == S_ISSUE) && (lat_op == OP_CLR));
  assign ctr_load  = (state == S_ISSUE) && (lat_op == OP_LOAD);

`ifdef COUNTER_ARB_SAT_EN
  localparam logic [WIDTH-1:0] CNT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  logic at_max;
  logic ovf_pend;

  assign at_max  = (count == CNT_MAX);
  assign ctr_inc = issue_inc & ~at_max;

  // Remember the suppressed increment so the flag lines up with gnt in ACK
  always_ff @(posedge clk) begin
    if (res)                     ovf_pend <= 1'b0;
    else if (state == S_ISSUE)   ovf_pend <= issue_inc & at_max;
  end

  assign ovf = (state == S_ACK) & ovf_pend;
`else
  assign ctr_inc = issue_inc;
  assign ovf     = 1'b0;
`endif

  always_comb begin
    gnt = '0;
    if (state == S_ACK) gnt[win] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  counter_arbiter_counter #(.WIDTH(WIDTH)) u_counter (
    .o    (count),
    .in   (lat_din),
    .res  (ctr_res),
    .load (ctr_load),
    .inc  (ctr_inc),
    .clk  (clk)
  );

endmodule

`default_nettype wire

// File: tb/tb_counter_arbiter.sv
// ============================================================================
// Module  : tb_counter_arbiter
// Purpose : Self-checking bench for counter_arbiter (NREQ=4, WIDTH=16).
//           Expected grant/count/ovf are produced by a small counter model
//           and queued when a request is driven, then popped when gnt pulses.
//           Honours COUNTER_ARB_SAT_EN for the INC-at-maximum expectation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  localparam logic [1:0] T_INC  = 2'b00;
  localparam logic [1:0] T_LOAD = 2'b01;
  localparam logic [1:0] T_CLR  = 2'b10;
  localparam logic [1:0] T_READ = 2'b11;

  logic                  clk = 1'b0;
  logic                  res;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  ovf;

  always #5 clk = ~clk;

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .res   (res),
    .req   (req),
    .op    (op),
    .din   (din),
    .gnt   (gnt),
    .count (count),
    .busy  (busy),
    .ovf   (ovf)
  );

  typedef struct packed {
    logic [NREQ-1:0]  g;
    logic [WIDTH-1:0] c;
    logic             o;
  } exp_t;

  typedef struct packed {
    logic [NREQ-1:0]  g;
    logic [WIDTH-1:0] c;
    logic             o;
    int               lat;
    bit               to;
  } obs_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model;
  int               checks = 0;
  int               errors = 0;

  // Model one operation and queue what the DUT should report at its grant
  task automatic push_exp(input int i, input logic [1:0] o, input logic [WIDTH-1:0] d);
    exp_t e;
    e.o = 1'b0;
    case (o)
      T_INC: begin
`ifdef COUNTER_ARB_SAT_EN
        if (model == 16'h7FFF) e.o = 1'b1;
        else                   model = model + 16'd1;
`else
        model = model + 16'd1;
`endif
      end
      T_LOAD:  model = d;
      T_CLR:   model = '0;
      default: ;
    endcase
    e.g = 4'b0001 << i;
    e.c = model;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [WIDTH-1:0] d);
    req[i]          = 1'b1;
    op[2*i +: 2]    = o;
    din[WIDTH*i +: WIDTH] = d;
  endtask

  // Wait up to 20 cycles for a grant, sampling 1 time unit after each edge
  task automatic wait_gnt(output obs_t ob);
    int k;
    ob = '0;
    ob.to = 1'b1;
    k = 0;
    while (ob.to && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (gnt != '0) begin
        ob.g = gnt; ob.c = count; ob.o = ovf; ob.lat = k; ob.to = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    req = '0; op = '0; din = '0;
    res = 1'b1;
    idle(2);
    res = 1'b0;
    model = '0;
    sb.delete();
  endtask

  // Drive one request, wait for its grant, drop the request after gnt
  task automatic run_one(input int i, input logic [1:0] o, input logic [WIDTH-1:0] d,
                         output obs_t ob);
    set_req(i, o, d);
    push_exp(i, o, d);
    wait_gnt(ob);
    req[i] = 1'b0;
  endtask

  task automatic test_reset();
    obs_t ob; exp_t e;
    apply_reset();
    checks++;
    if (count !== 16'h0000 || gnt !== 4'b0000 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%h gnt=%b busy=%b ovf=%b, want 0000/0000/0/0", count, gnt, busy, ovf);
    end
    // All requesters high: requester 0 wins first
    for (int i = 0; i < NREQ; i++) set_req(i, T_INC, '0);
    push_exp(0, T_INC, '0);
    wait_gnt(ob);
    req = '0;
    e = sb.pop_front();
    checks++;
    if (ob.to || ob.g !== e.g || ob.c !== e.c) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b count=%h to=%0d, want gnt=%b count=%h", ob.g, ob.c, ob.to, e.g, e.c);
    end
  endtask

  task automatic test_load();
    obs_t ob; exp_t e;
    idle(2);
    run_one(2, T_LOAD, 16'h8285, ob);
    e = sb.pop_front();
    checks++;
    if (ob.to || ob.g !== e.g || ob.c !== e.c || ob.o !== e.o || ob.lat != 2) begin
      errors++;
      $display("FAIL single_load: gnt=%b count=%h ovf=%b lat=%0d to=%0d, want gnt=%b count=%h ovf=%b lat=2",
               ob.g, ob.c, ob.o, ob.lat, ob.to, e.g, e.c, e.o);
    end
    checks++;
    if (e.c !== 16'h8285 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_value_busy: model=%h busy=%b, want 8285 busy=1", e.c, busy);
    end
  endtask

  task automatic test_round_robin();
    obs_t ob; exp_t e;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, T_INC, '0);
    for (int n = 0; n < 5; n++) push_exp(n % NREQ, T_INC, '0);
    for (int n = 0; n < 5; n++) begin
      wait_gnt(ob);
      e = sb.pop_front();
      checks++;
      if (ob.to || ob.g !== e.g || ob.c !== e.c || ob.lat != ((n == 0) ? 2 : 3)) begin
        errors++;
        $display("FAIL round_robin_%0d: gnt=%b count=%h lat=%0d to=%0d, want gnt=%b count=%h lat=%0d",
                 n, ob.g, ob.c, ob.lat, ob.to, e.g, e.c, (n == 0) ? 2 : 3);
      end
    end
    req = '0;
  endtask

  task automatic test_commit();
    obs_t ob; exp_t e; bit seen;
    idle(2);
    // Operation is latched; dropping req and changing op/din must not matter
    set_req(1, T_LOAD, 16'd12345);
    push_exp(1, T_LOAD, 16'd12345);
    @(posedge clk); #1;
    req = '0; op[3:2] = T_CLR; din[WIDTH +: WIDTH] = 16'h1111;
    wait_gnt(ob);
    e = sb.pop_front();
    checks++;
    if (ob.to || ob.g !== e.g || ob.c !== e.c) begin
      errors++;
      $display("FAIL commit_drop: gnt=%b count=%h to=%0d, want gnt=%b count=%h", ob.g, ob.c, ob.to, e.g, e.c);
    end
    // Reset during ISSUE aborts the operation
    idle(2);
    set_req(1, T_LOAD, 16'd999);
    @(posedge clk); #1;
    req = '0; res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0; model = '0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (gnt != '0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || count !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_op_reset: gnt_seen=%0d count=%h busy=%b, want 0/0000/0", seen, count, busy);
    end
    // Pointer returned to 0: all-high must grant requester 0
    for (int i = 0; i < NREQ; i++) set_req(i, T_INC, '0);
    push_exp(0, T_INC, '0);
    wait_gnt(ob);
    req = '0;
    e = sb.pop_front();
    checks++;
    if (ob.to || ob.g !== e.g || ob.c !== e.c) begin
      errors++;
      $display("FAIL reset_pointer: gnt=%b count=%h to=%0d, want gnt=%b count=%h", ob.g, ob.c, ob.to, e.g, e.c);
    end
  endtask

  task automatic test_clr_read();
    obs_t ob; exp_t e;
    int               idx_t[3] = '{2, 3, 0};
    logic [1:0]       op_t[3]  = '{T_LOAD, T_CLR, T_READ};
    logic [WIDTH-1:0] din_t[3] = '{16'd22222, 16'h5555, 16'h7777};
    for (int n = 0; n < 3; n++) begin
      idle(2);
      run_one(idx_t[n], op_t[n], din_t[n], ob);
      e = sb.pop_front();
      checks++;
      if (ob.to || ob.g !== e.g || ob.c !== e.c || ob.o !== e.o) begin
        errors++;
        $display("FAIL clr_read_%0d: gnt=%b count=%h ovf=%b to=%0d, want gnt=%b count=%h ovf=%b",
                 n, ob.g, ob.c, ob.o, ob.to, e.g, e.c, e.o);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t ob; exp_t e;
    int               idx_t[4] = '{1, 2, 3, 0};
    logic [1:0]       op_t[4]  = '{T_LOAD, T_INC, T_LOAD, T_INC};
    logic [WIDTH-1:0] din_t[4] = '{16'h7FFF, 16'h0000, 16'hFFFF, 16'h0000};
    for (int n = 0; n < 4; n++) begin
      idle(2);
      run_one(idx_t[n], op_t[n], din_t[n], ob);
      e = sb.pop_front();
      checks++;
      if (ob.to || ob.g !== e.g || ob.c !== e.c || ob.o !== e.o) begin
        errors++;
        $display("FAIL wrap_%0d: gnt=%b count=%h ovf=%b to=%0d, want gnt=%b count=%h ovf=%b",
                 n, ob.g, ob.c, ob.o, ob.to, e.g, e.c, e.o);
      end
    end
  endtask

  initial begin
    res = 1'b1; req = '0; op = '0; din = '0; model = '0;
    test_reset();
    test_load();
    test_round_robin();
    test_commit();
    test_clr_read();
    test_wrap();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
